// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;

    // Quotient reported when the divisor is zero (default width).
    localparam logic [DEF_DW-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] r_i,
    input  logic          bit_i,
    input  logic [VW-1:0] d_i,
    output logic [VW-1:0] r_o,
    output logic          q_bit_o
);

    // The shifted remainder needs one extra bit so the compare cannot overflow;
    // after restoring, the result is below the divisor and fits back in VW bits.
    logic [VW:0] r_shift;

    assign r_shift = {r_i, bit_i};

    always_comb begin
        q_bit_o = (r_shift >= {1'b0, d_i});
        r_o     = q_bit_o ? VW'(r_shift - {1'b0, d_i}) : r_shift[VW-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] q_sh_q, q_sh_d;
    logic [VW-1:0] d_q, d_d;
    logic [VW-1:0] r_q, r_d;
    logic          dz_q, dz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [VW-1:0] r_step;
    logic          q_bit;

    div_step #(.VW(VW)) u_step (
        .r_i     (r_q),
        .bit_i   (q_sh_q[DW-1]),
        .d_i     (d_q),
        .r_o     (r_step),
        .q_bit_o (q_bit)
    );

    always_comb begin
        state_d     = state_q;
        q_sh_d      = q_sh_q;
        d_d         = d_q;
        r_d         = r_q;
        dz_d        = dz_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    q_sh_d  = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    dz_d    = (divisor == '0);
                    cnt_d   = CW'(DW);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    q_sh_d = {q_sh_q[DW-2:0], q_bit};
                    r_d    = r_step;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    // Zero divisor still runs all DW steps so latency stays data-independent.
                    quotient_d  = dz_q ? {DW{1'b1}} : q_sh_q;
                    remainder_d = dz_q ? '0 : r_q;
                    dbz_d       = dz_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_sh_q      <= '0;
            d_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_sh_q      <= q_sh_d;
            d_q         <= d_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            cnt_q       <= cnt_d;
            // Registered so in_ready stays low until the first edge after reset release.
            in_ready_q  <= (state_d == IDLE);
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and sweep bench for seq_divider.
module tb_seq_divider;
    import div_pkg::*;

    localparam int DW  = 8;
    localparam int VW  = 4;
    localparam int LAT = DW + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Submit one operation, wait for the result, then complete the output handshake.
    // Called and returns at 1 time unit after a rising edge.
    task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int rdy_delay,
                         output logic [DW-1:0] q, output logic [VW-1:0] r, output logic dz,
                         output int lat);
        int guard = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose for %0d/%0d", a, b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) begin
            checks++; errors++;
            $display("FAIL result_timeout: out_valid never rose for %0d/%0d", a, b);
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        repeat (rdy_delay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        int            lat;
        int            stable_bad;
        int            seen_valid;

        vecs[0] = '{8'd200, 4'd7,  8'd28,        4'd4, 1'b0};
        vecs[1] = '{8'd15,  4'd15, 8'd1,         4'd0, 1'b0};
        vecs[2] = '{8'd0,   4'd3,  8'd0,         4'd0, 1'b0};
        vecs[3] = '{8'd255, 4'd1,  8'd255,       4'd0, 1'b0};
        vecs[4] = '{8'd255, 4'd15, 8'd17,        4'd0, 1'b0};
        vecs[5] = '{8'd7,   4'd9,  8'd0,         4'd7, 1'b0};
        vecs[6] = '{8'd100, 4'd0,  DBZ_QUOTIENT, 4'd0, 1'b1};
        vecs[7] = '{8'd100, 4'd3,  8'd33,        4'd1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        #3;
        check("rst_in_ready",  int'(in_ready),    0);
        check("rst_out_valid", int'(out_valid),   0);
        check("rst_quotient",  int'(quotient),    0);
        check("rst_remainder", int'(remainder),   0);
        check("rst_dbz",       int'(div_by_zero), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        check("rel_in_ready_high", int'(in_ready), 1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, q, r, dz, lat);
            $display("op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", vecs[i].a, vecs[i].b, q, r, dz, lat);
            check($sformatf("vec%0d_quotient", i),  int'(q),  int'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), int'(r),  int'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i),       int'(dz), int'(vecs[i].dz));
            check($sformatf("vec%0d_latency", i),   lat,      LAT);
            check($sformatf("vec%0d_post_valid", i), int'(out_valid), 0);
            check($sformatf("vec%0d_post_ready", i), int'(in_ready),  1);
        end

        // Backpressure: 200/7 held for 5 cycles while foreign in_valid pulses are offered
        in_valid = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, LAT);
        stable_bad = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0); dividend = 8'd99; divisor = 4'd5;
            @(posedge clk); #1;
            if (!out_valid || in_ready || quotient != 8'd28 || remainder != 4'd4 || div_by_zero)
                stable_bad++;
        end
        in_valid = 1'b0;
        check("bp_stable_cycles_bad", stable_bad, 0);
        check("bp_held_quotient", int'(quotient), 28);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        in_valid = 1'b1; dividend = 8'd15; divisor = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accepted", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op 15/15 after backpressure -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("bp_next_latency",  lat, LAT);
        check("bp_next_quotient", int'(quotient),  1);
        check("bp_next_remainder", int'(remainder), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Load nonzero held outputs so the asynchronous clear is observable
        do_op(8'd100, 4'd3, 0, q, r, dz, lat);
        check("pre_rst_quotient", int'(q), 33);

        // Reset during cycle 4 of a 200/7 run
        in_valid = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-run -> q=%0d r=%0d dz=%0d valid=%0d ready=%0d",
                 quotient, remainder, div_by_zero, out_valid, in_ready);
        check("mid_rst_quotient",  int'(quotient),    0);
        check("mid_rst_remainder", int'(remainder),   0);
        check("mid_rst_dbz",       int'(div_by_zero), 0);
        check("mid_rst_out_valid", int'(out_valid),   0);
        check("mid_rst_in_ready",  int'(in_ready),    0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        check("mid_rel_in_ready_high", int'(in_ready), 1);
        seen_valid = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        out_ready = 1'b0;
        check("mid_rst_stale_valid", seen_valid, 0);

        // Exhaustive sweep with random input and output gaps
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                do_op(DW'(a), VW'(b), ($urandom_range(0, 3) == 0) ? 1 : 0, q, r, dz, lat);
                $display("sweep %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q, r, dz, lat);
                check("sweep_latency", lat, LAT);
                if (b != 0) begin
                    check("sweep_quotient",  int'(q), a / b);
                    check("sweep_remainder", int'(r), a % b);
                    check("sweep_identity",  int'(q) * b + int'(r), a);
                    check("sweep_rem_lt_div", int'(int'(r) < b), 1);
                    check("sweep_dbz", int'(dz), 0);
                end else begin
                    check("sweep_dbz_quotient",  int'(q), int'(DBZ_QUOTIENT));
                    check("sweep_dbz_remainder", int'(r), 0);
                    check("sweep_dbz", int'(dz), 1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
